mem_port_arbiter: RTL

- Shares the single data-memory port between the fetch stage (IF) and the stage-4 data requester (DS): stores, PSH/POP, CALL/RET stack traffic and LDA/STA.
- Grants one requester at a time and drives the memory port.
- Waits a fixed memory latency, then returns the response with a one-cycle valid pulse.
- Drives stall_if so the fetch/decode stages freeze while DS owns the port.

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_port_arbiter_lat_timer.sv | 36 +++
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the data-memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_IF, BUSY_DS)
//   owner_e     : which requester currently owns the memory port
//   DEF_*       : default widths and timing used by the arbiter parameters
//   LAT_W       : latency counter width for the default MEM_LAT, clog2(MEM_LAT+1)
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 8;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 3;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned bits_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned LAT_W = bits_for(DEF_MEM_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DS = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DS   = 2'd2
  } owner_e;

  function automatic owner_e owner_of(input arb_state_e st);
    case (st)
      BUSY_IF: return OWN_IF;
      BUSY_DS: return OWN_DS;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// lat_timer
// Loadable down-counter that times the fixed memory latency of one access.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : starting count, normally MEM_LAT
//   done      : high while the count equals 1, i.e. the access completes
//               on the coming edge
module lat_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  always_comb begin
    done = (cnt == W'(1));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single data-memory port between instruction fetch (IF) and the
// stage-4 data requester (DS). One requester is granted at a time; after a
// fixed MEM_LAT the read data (or write ack) is returned with a one-cycle
// valid pulse. stall_if freezes fetch/decode while DS owns the port or while
// a fetch is waiting. All outputs are registered.
//
// Optional build macro: MEM_ARB_BACK2BACK_EN
//   undefined : FSM returns through IDLE for one cycle after each access
//   defined   : arbitration also runs on the completion edge, so the next
//               grant can coincide with the valid pulse
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rdata/if_valid    fetch grant pulse, data, data-valid pulse
//   ds_req/ds_we/ds_addr/ds_wdata  data request (held until ds_gnt)
//   ds_gnt/ds_rdata/ds_valid    data grant pulse, read data, done pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command
//   mem_rdata                   memory read data
//   stall_if                    freeze fetch/decode
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ds_req,
  input  logic              ds_we,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [DATA_W-1:0] ds_wdata,
  output logic              ds_gnt,
  output logic [DATA_W-1:0] ds_rdata,
  output logic              ds_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  localparam int unsigned CNT_W = bits_for(MEM_LAT);
  localparam int unsigned SW    = bits_for(STARVE_MAX);

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e       state, state_next;
  owner_e           owner;
  logic [SW-1:0]    starve_cnt, starve_next;
  logic             ds_wr_q, ds_wr_next;
  logic             lat_done;
  logic             complete_if, complete_ds;
  logic             arb_open;
  logic             win_if, win_ds;
  logic             timer_load;

  logic              if_gnt_n, if_valid_n, ds_gnt_n, ds_valid_n;
  logic              mem_en_n, mem_we_n, stall_if_n;
  logic [DATA_W-1:0] if_rdata_n, ds_rdata_n, mem_wdata_n;
  logic [ADDR_W-1:0] mem_addr_n;

  // Latency timer: loaded on every grant edge, done flags the completion edge.
  lat_timer #(
    .W (CNT_W)
  ) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LAT_LOAD),
    .done     (lat_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ds_wr_q    <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      ds_wr_q    <= ds_wr_next;
    end
  end

  // Arbitration and next state
  always_comb begin
    owner       = owner_of(state);
    complete_if = (owner == OWN_IF) && lat_done;
    complete_ds = (owner == OWN_DS) && lat_done;
`ifdef MEM_ARB_BACK2BACK_EN
    // The completion edge doubles as an arbitration edge, removing the bubble.
    arb_open = (owner == OWN_NONE) || complete_if || complete_ds;
`else
    arb_open = (owner == OWN_NONE);
`endif
    // DS has priority until IF has lost STARVE_MAX contested rounds in a row.
    win_ds     = arb_open && ds_req && (!if_req || (starve_cnt < STARVE_LIM));
    win_if     = arb_open && !win_ds && if_req;
    timer_load = win_if || win_ds;

    state_next = state;
    if (win_ds) begin
      state_next = BUSY_DS;
    end else if (win_if) begin
      state_next = BUSY_IF;
    end else if (complete_if || complete_ds) begin
      state_next = IDLE;
    end

    starve_next = starve_cnt;
    if (win_if) begin
      starve_next = '0;
    end else if (win_ds && if_req && (starve_cnt != STARVE_LIM)) begin
      starve_next = starve_cnt + SW'(1);
    end

    // Remember whether the DS access in flight is a write, since mem_we
    // itself is only a one-cycle command.
    ds_wr_next = win_ds ? ds_we : ds_wr_q;
  end

  // Next values of the registered outputs
  always_comb begin
    if_gnt_n    = win_if;
    ds_gnt_n    = win_ds;
    mem_en_n    = win_if || win_ds;
    mem_we_n    = win_ds && ds_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    if (win_ds) begin
      mem_addr_n  = ds_addr;
      mem_wdata_n = ds_wdata;
    end else if (win_if) begin
      mem_addr_n  = if_addr;
    end

    if_valid_n = complete_if;
    if_rdata_n = complete_if ? mem_rdata : if_rdata;
    ds_valid_n = complete_ds;
    ds_rdata_n = (complete_ds && !ds_wr_q) ? mem_rdata : ds_rdata;

    // Owner DS covers the grant edge through the ds_valid cycle; a waiting
    // fetch also stalls until it is actually granted.
    stall_if_n = win_ds || (owner == OWN_DS) || (if_req && !win_if);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      ds_gnt    <= 1'b0;
      ds_valid  <= 1'b0;
      ds_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      stall_if  <= 1'b0;
    end else begin
      if_gnt    <= if_gnt_n;
      if_valid  <= if_valid_n;
      if_rdata  <= if_rdata_n;
      ds_gnt    <= ds_gnt_n;
      ds_valid  <= ds_valid_n;
      ds_rdata  <= ds_rdata_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      stall_if  <= stall_if_n;
    end
  end

endmodule
